// File: rtl/farbborg_framebuf.sv
// Double-buffered asymmetric frame RAM: narrow writes to the back page, wide reads from the front page.
// Define FRAMEBUF_OUTREG_EN to add an output pipeline register (read latency 2 instead of 1).
module farbborg_framebuf #(
  parameter int WR_AW    = 10,
  parameter int WR_DW    = 8,
  parameter int RD_LANES = 8,
  parameter int LW       = $clog2(RD_LANES),
  parameter int RD_AW    = WR_AW - LW,
  parameter int RD_DW    = WR_DW * RD_LANES
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WR_AW-1:0] wr_addr_i,
  input  logic [WR_DW-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [RD_AW-1:0] rd_addr_i,
  output logic [RD_DW-1:0] rd_data_o,
  output logic             rd_valid_o,
  input  logic             swap_req_i,
  input  logic             frame_sync_i,
  output logic             swap_pend_o,
  output logic             swap_ack_o,
  output logic             front_page_o
);

  typedef enum logic {SWAP_IDLE, SWAP_PEND} swap_state_t;

  swap_state_t state_q, state_d;
  logic        swap_fire;
  logic        front_page_q;
  logic        swap_ack_q;

  // Swap request tracking: a second request while pending is absorbed.
  always_comb begin
    state_d   = state_q;
    swap_fire = frame_sync_i && (swap_req_i || state_q == SWAP_PEND);
    if (swap_fire)       state_d = SWAP_IDLE;
    else if (swap_req_i) state_d = SWAP_PEND;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= SWAP_IDLE;
      front_page_q <= 1'b0;
      swap_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      front_page_q <= front_page_q ^ swap_fire;
      swap_ack_q   <= swap_fire;
    end
  end

  assign swap_pend_o  = (state_q == SWAP_PEND);
  assign swap_ack_o   = swap_ack_q;
  assign front_page_o = front_page_q;

  logic [RD_DW-1:0] bank_q;
  logic             bank_valid_q;
  logic [RD_AW:0]   wr_row;
  logic [RD_AW:0]   rd_row;

  assign wr_row = {~front_page_q, wr_addr_i[WR_AW-1:LW]};
  assign rd_row = {front_page_q, rd_addr_i};

  for (genvar k = 0; k < RD_LANES; k++) begin : g_bank
    logic [WR_DW-1:0] mem [2**(RD_AW+1)];

    // NOTE: the array itself is never reset; only the bank output register is.
    always_ff @(posedge clk_i) begin
      if (wr_en_i && wr_addr_i[LW-1:0] == LW'(k))
        mem[wr_row] <= wr_data_i;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i)        bank_q[k*WR_DW +: WR_DW] <= '0;
      else if (rd_en_i) bank_q[k*WR_DW +: WR_DW] <= mem[rd_row];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) bank_valid_q <= 1'b0;
    else       bank_valid_q <= rd_en_i;
  end

`ifdef FRAMEBUF_OUTREG_EN
  logic [RD_DW-1:0] out_q;
  logic             out_valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bank_valid_q;
      if (bank_valid_q) out_q <= bank_q;
    end
  end

  assign rd_data_o  = out_q;
  assign rd_valid_o = out_valid_q;
`else
  assign rd_data_o  = bank_q;
  assign rd_valid_o = bank_valid_q;
`endif

endmodule

// File: tb/tb_farbborg_framebuf.sv
// Directed self-checking bench for farbborg_framebuf with default parameters.
module tb_farbborg_framebuf;

`ifdef FRAMEBUF_OUTREG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        wr_en_i = 1'b0;
  logic [9:0]  wr_addr_i = '0;
  logic [7:0]  wr_data_i = '0;
  logic        rd_en_i = 1'b0;
  logic [6:0]  rd_addr_i = '0;
  logic [63:0] rd_data_o;
  logic        rd_valid_o;
  logic        swap_req_i = 1'b0;
  logic        frame_sync_i = 1'b0;
  logic        swap_pend_o;
  logic        swap_ack_o;
  logic        front_page_o;

  int checks = 0;
  int errors = 0;

  farbborg_framebuf dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .rd_en_i      (rd_en_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .rd_valid_o   (rd_valid_o),
    .swap_req_i   (swap_req_i),
    .frame_sync_i (frame_sync_i),
    .swap_pend_o  (swap_pend_o),
    .swap_ack_o   (swap_ack_o),
    .front_page_o (front_page_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [63:0] lane_word;

    // Reset and idle state
    tick(2);
    rst_i = 1'b0;
    tick();
    check("rst_front", 64'(front_page_o), 64'd0);
    check("rst_pend",  64'(swap_pend_o),  64'd0);
    check("rst_ack",   64'(swap_ack_o),   64'd0);
    check("rst_valid", 64'(rd_valid_o),   64'd0);
    check("rst_data",  rd_data_o,         64'd0);

    // Read latency
    rd_en_i = 1'b1; rd_addr_i = 7'd0;
    tick();
    rd_en_i = 1'b0;
    if (L == 2) begin
      check("lat_early", 64'(rd_valid_o), 64'd0);
      tick();
    end
    check("lat_valid", 64'(rd_valid_o), 64'd1);
    tick();
    check("lat_drop", 64'(rd_valid_o), 64'd0);

    // Fill back page row 0, then same-cycle request + sync swap
    for (int i = 0; i < 8; i++) begin
      wr_en_i = 1'b1; wr_addr_i = 10'(i); wr_data_i = 8'(8'h11 * (i + 1));
      tick();
    end
    wr_en_i = 1'b0;
    swap_req_i = 1'b1; frame_sync_i = 1'b1;
    tick();
    swap_req_i = 1'b0; frame_sync_i = 1'b0;
    check("imm_front", 64'(front_page_o), 64'd1);
    check("imm_ack",   64'(swap_ack_o),   64'd1);
    check("imm_pend",  64'(swap_pend_o),  64'd0);
    tick();
    check("imm_ack_drop", 64'(swap_ack_o), 64'd0);

    rd_en_i = 1'b1; rd_addr_i = 7'd0;
    tick();
    rd_en_i = 1'b0;
    tick(L - 1);
    check("row0_valid", 64'(rd_valid_o), 64'd1);
    check("row0_data",  rd_data_o, 64'h8877665544332211);
    tick(3);
    check("row0_hold",  rd_data_o, 64'h8877665544332211);

    // Pending request waits for frame sync
    swap_req_i = 1'b1;
    tick();
    swap_req_i = 1'b0;
    check("pend_rise",  64'(swap_pend_o),  64'd1);
    check("pend_front", 64'(front_page_o), 64'd1);
    tick(3);
    check("pend_hold",  64'(swap_pend_o),  64'd1);
    check("pend_noack", 64'(swap_ack_o),   64'd0);
    frame_sync_i = 1'b1;
    tick();
    frame_sync_i = 1'b0;
    check("pend_front_tgl", 64'(front_page_o), 64'd0);
    check("pend_ack",       64'(swap_ack_o),   64'd1);
    check("pend_clear",     64'(swap_pend_o),  64'd0);
    tick();
    check("pend_ack_drop",  64'(swap_ack_o),   64'd0);

    // Double request toggles once; bare sync is a no-op
    swap_req_i = 1'b1;
    tick(2);
    swap_req_i = 1'b0;
    check("dbl_pend", 64'(swap_pend_o), 64'd1);
    frame_sync_i = 1'b1;
    tick();
    check("dbl_front", 64'(front_page_o), 64'd1);
    tick();
    frame_sync_i = 1'b0;
    check("dbl_nop_front", 64'(front_page_o), 64'd1);
    check("dbl_nop_ack",   64'(swap_ack_o),   64'd0);
    tick();

    // Write and read in the swap cycle: write goes to page 0, read sees page 1
    swap_req_i = 1'b1; frame_sync_i = 1'b1;
    wr_en_i = 1'b1; wr_addr_i = 10'd3; wr_data_i = 8'hAA;
    rd_en_i = 1'b1; rd_addr_i = 7'd0;
    tick();
    swap_req_i = 1'b0; frame_sync_i = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0;
    tick(L - 1);
    check("sc_old_page", rd_data_o, 64'h8877665544332211);
    check("sc_front",    64'(front_page_o), 64'd0);
    rd_en_i = 1'b1; rd_addr_i = 7'd0;
    tick();
    rd_en_i = 1'b0;
    tick(L - 1);
    lane_word = rd_data_o;
    check("sc_lane3", 64'(lane_word[31:24]), 64'hAA);

    // Reset with a swap pending and a read issued
    swap_req_i = 1'b1; frame_sync_i = 1'b1;
    tick();
    frame_sync_i = 1'b0;
    tick();
    swap_req_i = 1'b0;
    check("pre_rst_front", 64'(front_page_o), 64'd1);
    check("pre_rst_pend",  64'(swap_pend_o),  64'd1);
    rd_en_i = 1'b1; rst_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
    check("mid_rst_pend",  64'(swap_pend_o),  64'd0);
    check("mid_rst_front", 64'(front_page_o), 64'd0);
    check("mid_rst_valid", 64'(rd_valid_o),   64'd0);
    check("mid_rst_data",  rd_data_o,         64'd0);
    rst_i = 1'b0;
    tick();
    check("post_rst_valid", 64'(rd_valid_o), 64'd0);
    tick();
    check("post_rst_valid2", 64'(rd_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
